// File: rtl/overtime_fine_meter.sv
// Overtime fine meter: times laundry pickup after a wash and accrues a BCD fine after a grace period.
// Optional: define FINE_CAP_EN to saturate the fine at FINE_CAP and hold the buzzer steady once capped.
module overtime_fine_meter #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned GRACE_S  = 10,
    parameter int unsigned PERIOD_S = 5,
    parameter logic [11:0] FINE_CAP = 12'h050
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        collect_i,
    input  logic [11:0] fine_rate_i,
    output logic [11:0] fine_o,
    output logic [11:0] elapsed_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        buzzer_o,
    output logic [1:0]  phase_o
);
    typedef enum logic [1:0] {StIdle = 2'b00, StWait = 2'b01, StAccrue = 2'b10, StDone = 2'b11}
        state_e;

    localparam int unsigned PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned GraceEff = (GRACE_S == 0) ? 1 : GRACE_S;
    localparam int unsigned PerEff   = (PERIOD_S == 0) ? 1 : PERIOD_S;
    localparam int unsigned CW       = $clog2(PerEff + 1);
`ifdef FINE_CAP_EN
    localparam bit CapEn = 1'b1;
`else
    localparam bit CapEn = 1'b0;
`endif
    localparam logic [11:0] FineMax = CapEn ? FINE_CAP : 12'h999;

    function automatic logic [11:0] to_bcd(input int unsigned v);
        int unsigned s;
        s = (v > 999) ? 999 : v;
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    localparam logic [11:0] GraceBcd = to_bcd(GraceEff);

    // Returns {carry_out, sum} of a 3-digit BCD add.
    function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] r;
        logic [4:0]  s;
        logic        c;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
            c = (s > 5'd9);
            if (c) s = s - 5'd10;
            r[4*i+:4] = s[3:0];
        end
        r[12] = c;
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] period_q, period_d;
    logic [11:0]   fine_q, fine_d, elapsed_q, elapsed_d, rate_q, rate_d, rate_clamped;
    logic          busy_q, busy_d, done_q, done_d, buzzer_q, buzzer_d;
    logic          running, tick, period_hit;
    logic [12:0]   elapsed_sum, fine_sum;
    logic [11:0]   elapsed_inc, fine_add;

    assign running     = (state_q == StWait) || (state_q == StAccrue);
    assign tick        = running && (presc_q == PW'(CLK_HZ - 1));
    assign period_hit  = (period_q == CW'(PerEff - 1));
    assign elapsed_sum = bcd_add(elapsed_q, 12'h001);
    assign elapsed_inc = elapsed_sum[12] ? 12'h999 : elapsed_sum[11:0];
    assign fine_sum    = bcd_add(fine_q, rate_q);
    assign fine_add    = (fine_sum[12] || (fine_sum[11:0] > FineMax)) ? FineMax : fine_sum[11:0];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rate_clamped[4*i+:4] = (fine_rate_i[4*i+:4] > 4'd9) ? 4'd9 : fine_rate_i[4*i+:4];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start_i) state_d = StWait;
            StWait: begin
                if (collect_i)                         state_d = StDone;
                else if (tick && elapsed_inc == GraceBcd) state_d = StAccrue;
            end
            StAccrue: if (collect_i) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values; collect outranks a same-cycle tick.
    always_comb begin
        presc_d   = presc_q;
        period_d  = period_q;
        fine_d    = fine_q;
        elapsed_d = elapsed_q;
        rate_d    = rate_q;
        if (running) presc_d = tick ? '0 : presc_q + 1'b1;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    presc_d   = '0;
                    period_d  = '0;
                    fine_d    = '0;
                    elapsed_d = '0;
                    rate_d    = rate_clamped;
                end
            end
            StWait, StAccrue: begin
                if (collect_i) begin
                    presc_d = '0;
                end else if (tick) begin
                    elapsed_d = elapsed_inc;
                    if (state_q == StWait) begin
                        if (elapsed_inc == GraceBcd) begin
                            fine_d   = fine_add;
                            period_d = '0;
                        end
                    end else if (period_hit) begin
                        fine_d   = fine_add;
                        period_d = '0;
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        busy_d   = (state_d == StWait) || (state_d == StAccrue);
        done_d   = (state_d == StDone) && (state_q != StDone);
        buzzer_d = (state_d == StAccrue) &&
                   ((presc_d < PW'(CLK_HZ / 2)) || (CapEn && fine_d == FineMax));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q   <= '0;
            period_q  <= '0;
            fine_q    <= '0;
            elapsed_q <= '0;
            rate_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            buzzer_q  <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            period_q  <= period_d;
            fine_q    <= fine_d;
            elapsed_q <= elapsed_d;
            rate_q    <= rate_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            buzzer_q  <= buzzer_d;
        end
    end

    assign fine_o    = fine_q;
    assign elapsed_o = elapsed_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign buzzer_o  = buzzer_q;
    assign phase_o   = state_q;
endmodule

// File: tb/tb_overtime_fine_meter.sv
// Scoreboard bench for overtime_fine_meter with CLK_HZ=10, GRACE_S=3, PERIOD_S=2.
module tb_overtime_fine_meter;
    logic        clk = 1'b0;
    logic        rst_ni, start, collect;
    logic [11:0] fine_rate, fine, elapsed;
    logic        busy, done, buzzer;
    logic [1:0]  phase;

    overtime_fine_meter #(
        .CLK_HZ(10), .GRACE_S(3), .PERIOD_S(2), .FINE_CAP(12'h050)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .collect_i(collect),
        .fine_rate_i(fine_rate), .fine_o(fine), .elapsed_o(elapsed), .busy_o(busy),
        .done_o(done), .buzzer_o(buzzer), .phase_o(phase)
    );

    always #5 clk = ~clk;

    typedef struct {logic [11:0] fine; logic [11:0] elapsed;} exp_t;
    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   buzz_seen;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (buzzer) buzz_seen = 1'b1;
        if (rst_ni && done) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1, expected none (fine %h)", fine);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_fine", fine, e.fine);
                chk("done_elapsed", elapsed, e.elapsed);
                chk("done_phase", {10'b0, phase}, 12'h3);
                chk("done_busy", {11'b0, busy}, 12'h0);
            end
        end
    end

    task automatic start_pulse(input logic [11:0] r);
        @(negedge clk);
        start = 1'b1;
        fine_rate = r;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic collect_pulse(input logic [11:0] f, input logic [11:0] e);
        exp_t x;
        x.fine = f;
        x.elapsed = e;
        sb_q.push_back(x);
        collect = 1'b1;
        @(posedge clk);
        #1 collect = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_elapsed(input logic [11:0] target);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (elapsed == target) found = 1'b1;
        end
        if (!found) chk("elapsed_timeout", elapsed, target);
    endtask

    initial begin
        rst_ni = 1'b0;
        start = 1'b0;
        collect = 1'b0;
        fine_rate = '0;
        #2;
        chk("rst_phase", {10'b0, phase}, 12'h0);
        chk("rst_fine", fine, 12'h000);
        chk("rst_elapsed", elapsed, 12'h000);
        chk("rst_flags", {9'b0, busy, done, buzzer}, 12'h0);
        @(negedge clk) rst_ni = 1'b1;

        // Collect inside the grace period.
        buzz_seen = 1'b0;
        start_pulse(12'h028);
        wait_elapsed(12'h002);
        collect_pulse(12'h000, 12'h002);
        chk("grace_phase", {10'b0, phase}, 12'h3);
        chk("grace_buzzer_never", {11'b0, buzz_seen}, 12'h0);

        // Accrual from DONE restart, with buzzer cadence.
        start_pulse(12'h028);
        @(negedge clk);
        chk("restart_fine", fine, 12'h000);
        chk("restart_elapsed", elapsed, 12'h000);
        chk("restart_phase", {10'b0, phase}, 12'h1);
        wait_elapsed(12'h003);
        chk("acc_fine3", fine, 12'h028);
        chk("acc_phase", {10'b0, phase}, 12'h2);
        chk("buz_p0", {11'b0, buzzer}, 12'h1);
        repeat (4) @(negedge clk);
        chk("buz_p4", {11'b0, buzzer}, 12'h1);
        @(negedge clk);
        chk("buz_p5", {11'b0, buzzer}, 12'h0);
        repeat (4) @(negedge clk);
        chk("buz_p9", {11'b0, buzzer}, 12'h0);
        @(negedge clk);
        chk("buz_wrap", {11'b0, buzzer}, 12'h1);
        wait_elapsed(12'h005);
        chk("acc_fine5", fine, 12'h056);
        wait_elapsed(12'h007);
        chk("acc_fine7", fine, 12'h084);
        wait_elapsed(12'h009);
        chk("acc_fine9", fine, 12'h112);
        wait_elapsed(12'h010);
        collect_pulse(12'h112, 12'h010);

        // Collect on the wrap cycle of tick 5 beats the tick.
        start_pulse(12'h028);
        wait_elapsed(12'h004);
        chk("tie_fine4", fine, 12'h028);
        repeat (9) @(posedge clk);
        #1 collect = 1'b1;
        sb_q.push_back('{fine: 12'h028, elapsed: 12'h004});
        @(posedge clk);
        #1 collect = 1'b0;
        repeat (3) @(negedge clk);

        // Saturation.
`ifdef FINE_CAP_EN
        start_pulse(12'h030);
        wait_elapsed(12'h003);
        chk("cap_fine3", fine, 12'h030);
        wait_elapsed(12'h005);
        chk("cap_fine5", fine, 12'h050);
        buzz_seen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!buzzer) buzz_seen = 1'b0;
        end
        chk("cap_buzzer_steady", {11'b0, buzz_seen}, 12'h1);
        wait_elapsed(12'h007);
        chk("cap_fine7", fine, 12'h050);
        collect_pulse(12'h050, 12'h007);
`else
        start_pulse(12'h500);
        wait_elapsed(12'h003);
        chk("sat_fine3", fine, 12'h500);
        wait_elapsed(12'h005);
        chk("sat_fine5", fine, 12'h999);
        wait_elapsed(12'h007);
        chk("sat_fine7", fine, 12'h999);
        collect_pulse(12'h999, 12'h007);
`endif

        // Invalid rate digit, start ignored in WAIT, then reset mid-ACCRUE.
        start_pulse(12'h0A5);
        wait_elapsed(12'h001);
        start = 1'b1;
        fine_rate = 12'h000;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("wait_start_elapsed", elapsed, 12'h001);
        chk("wait_start_phase", {10'b0, phase}, 12'h1);
        wait_elapsed(12'h003);
        chk("clamp_fine", fine, 12'h095);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("arst_phase", {10'b0, phase}, 12'h0);
        chk("arst_fine", fine, 12'h000);
        chk("arst_elapsed", elapsed, 12'h000);
        chk("arst_flags", {9'b0, busy, done, buzzer}, 12'h0);
        @(negedge clk) rst_ni = 1'b1;

        // Collect in IDLE is ignored.
        collect = 1'b1;
        @(posedge clk);
        #1 collect = 1'b0;
        @(negedge clk);
        chk("idle_collect_phase", {10'b0, phase}, 12'h0);

        start_pulse(12'h028);
        wait_elapsed(12'h003);
        chk("post_rst_fine", fine, 12'h028);
        collect_pulse(12'h028, 12'h003);
        chk("sb_drained", 12'(sb_q.size()), 12'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
